// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_pkg
//  Description : Shared definitions for the parametrised LIFO stack:
//                operation encoding and an address-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package stack_pkg;

    // Operation code formed as {push, pop}
    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    // Bits needed to address 'depth' entries (at least 1)
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
//  Module      : stack_mem
//  Description : DEPTH x WIDTH register file for the stack. One synchronous
//                write port, one asynchronous read port. Contents are not
//                reset.
//  Revision    : 1.0  initial release
// ============================================================================
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: storage only, no reset so the array maps onto plain flops/RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational; the caller keeps raddr within range
    assign rdata = mem[raddr];

endmodule : stack_mem
`default_nettype wire

// File: rtl/param_stack.sv
`default_nettype none
// ============================================================================
//  Module      : param_stack
//  Description : Parametrised synchronous LIFO stack with count/full/empty
//                status, overflow/underflow pulses and a single-cycle
//                replace-top operation (push and pop together).
//  Revision    : 1.0  initial release
// ============================================================================
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] D_out,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int               AW       = addr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Stack pointer: number of stored entries, top lives at sp-1
    logic [CNT_W-1:0] sp;
    logic [1:0]       op;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    assign op    = {push, pop};
    assign count = sp;

    // Read address always points at the top entry; parked at 0 when empty
    assign mem_raddr = empty ? '0 : AW'(sp - ONE_CNT);
    assign top       = empty ? '0 : mem_rdata;

    // Write-port steering: push writes above the top, replace overwrites it
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = AW'(sp);
        if (!RST) begin
            if (op == OP_PUSH && !full) begin
                mem_we    = 1'b1;
                mem_waddr = AW'(sp);
            end else if (op == OP_REPLACE && !empty) begin
                mem_we    = 1'b1;
                mem_waddr = AW'(sp - ONE_CNT);
            end
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Pointer, status flags, popped word and one-cycle pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            sp        <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            D_out     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        sp    <= sp + ONE_CNT;
                        empty <= 1'b0;
                        full  <= ((sp + ONE_CNT) == FULL_CNT);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        D_out     <= mem_rdata;
                        pop_valid <= 1'b1;
                        sp        <= sp - ONE_CNT;
                        full      <= 1'b0;
                        empty     <= (sp == ONE_CNT);
                    end
                end
                OP_REPLACE: begin
                    // Empty stack: the pushed word passes straight through
                    D_out     <= empty ? data : mem_rdata;
                    pop_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : param_stack
`default_nettype wire

// File: tb/tb_param_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_stack
//  Description : Scoreboard bench for param_stack (WIDTH=8, DEPTH=4) with a
//                queue-based behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [WIDTH-1:0] D_out;
    logic             pop_valid;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             pv;
        logic [CNT_W-1:0] cnt;
        logic             emp;
        logic             ful;
        logic             ov;
        logic             un;
        logic [WIDTH-1:0] tp;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] m_dout = '0;
    bit               stim_done = 0;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .pop       (pop),
        .data      (data),
        .D_out     (D_out),
        .pop_valid (pop_valid),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the stack must show after it
    task automatic cycle(input bit r, input bit pu, input bit po, input logic [WIDTH-1:0] d);
        exp_t e;
        @(negedge CLK);
        RST  = r;
        push = pu;
        pop  = po;
        data = d;
        e.pv = 1'b0;
        e.ov = 1'b0;
        e.un = 1'b0;
        if (r) begin
            stk.delete();
            m_dout = '0;
        end else if (pu && !po) begin
            if (stk.size() == DEPTH) e.ov = 1'b1;
            else stk.push_back(d);
        end else if (po && !pu) begin
            if (stk.size() == 0) e.un = 1'b1;
            else begin
                m_dout = stk.pop_back();
                e.pv = 1'b1;
            end
        end else if (pu && po) begin
            e.pv = 1'b1;
            if (stk.size() == 0) m_dout = d;
            else begin
                m_dout = stk[stk.size() - 1];
                stk[stk.size() - 1] = d;
            end
        end
        e.dout = m_dout;
        e.cnt  = CNT_W'(stk.size());
        e.emp  = (stk.size() == 0);
        e.ful  = (stk.size() == DEPTH);
        e.tp   = (stk.size() == 0) ? '0 : stk[stk.size() - 1];
        exp_q.push_back(e);
    endtask

    // Monitor: after every active edge compare the DUT against the next expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("d_out",     D_out,     e.dout);
                chk("pop_valid", pop_valid, e.pv);
                chk("count",     count,     e.cnt);
                chk("empty",     empty,     e.emp);
                chk("full",      full,      e.ful);
                chk("overflow",  overflow,  e.ov);
                chk("underflow", underflow, e.un);
                chk("top",       top,       e.tp);
            end
        end
    end

    initial begin : stimulus
        // Reset, push three, pop three
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 0, 8'h11);
        cycle(0, 1, 0, 8'h22);
        cycle(0, 1, 0, 8'h33);
        cycle(0, 0, 0, 8'h00);
        repeat (3) cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);
        // Fill, overflow, then pop
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'hA0 + 8'(i));
        cycle(0, 1, 0, 8'hFF);
        cycle(0, 1, 0, 8'hFE);
        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);
        // Underflow right after reset, back to back
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);
        // Replace on partial and full stack
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 0, 8'h10);
        cycle(0, 1, 0, 8'h20);
        cycle(0, 1, 1, 8'h55);
        cycle(0, 1, 0, 8'h66);
        cycle(0, 1, 0, 8'h77);
        cycle(0, 1, 1, 8'h88);
        cycle(0, 0, 1, 8'h00);
        // Replace on empty stack bypasses the word
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 1, 8'h77);
        cycle(0, 0, 0, 8'h00);
        // Reset dominates a simultaneous push
        cycle(0, 1, 0, 8'h01);
        cycle(0, 1, 0, 8'h02);
        cycle(1, 1, 0, 8'h03);
        cycle(0, 0, 1, 8'h00);
        // Randomised traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
        end
        cycle(0, 0, 0, 8'h00);
        repeat (3) @(negedge CLK);
        stim_done = 1;
    end

    initial begin : finisher
        fork
            wait (stim_done);
            #100000;
        join_any
        disable fork;
        checks++;
        if (!stim_done || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: done=%0d pending=%0d required done=1 pending=0", stim_done, exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_param_stack
`default_nettype wire
